// File: rtl/complex_mult_pipe_pkg.sv
// Shared width helpers and parameter-legality checks for the pipelined complex multiplier.
package complex_mult_pipe_pkg;

  function automatic int full_width(input int dina_w, input int dinb_w);
    return dina_w + dinb_w + 1;
  endfunction

  // Saturation is only needed when the shifted result can be wider than the output.
  function automatic bit sat_needed(input int width_in, input int shift, input int width_out);
    return width_out < (width_in - shift);
  endfunction

  function automatic bit params_legal(input int dina_w, input int dinb_w,
                                      input int shift, input int dout_w);
    return (dina_w >= 2) && (dinb_w >= 2) && (dout_w >= 2) &&
           (shift >= 0) && (shift < full_width(dina_w, dinb_w));
  endfunction

endpackage

// File: rtl/complex_mult_pipe_round_sat.sv
// Combinational round-half-up, arithmetic right shift and signed saturation with a clamp flag.
module complex_mult_pipe_round_sat
  import complex_mult_pipe_pkg::*;
#(
  parameter int WIDTH_IN  = 17,
  parameter int SHIFT     = 0,
  parameter int WIDTH_OUT = 17
) (
  input  logic signed [WIDTH_IN-1:0]  din,
  output logic signed [WIDTH_OUT-1:0] dout,
  output logic                        sat
);

  // One guard bit above the input keeps the rounding add from wrapping.
  localparam int W_EXT   = WIDTH_IN + 1;
  localparam int W_WORK  = (WIDTH_OUT > W_EXT) ? WIDTH_OUT : W_EXT;
  localparam int RND_POS = (SHIFT > 0) ? SHIFT - 1 : 0;
  localparam logic signed [W_WORK-1:0] RND_C = (SHIFT > 0) ? (W_WORK'(1) << RND_POS) : '0;

  logic signed [W_WORK-1:0] ext;
  logic signed [W_WORK-1:0] rnd;
  logic signed [W_WORK-1:0] shd;

  always_comb begin
    ext = {{(W_WORK-WIDTH_IN){din[WIDTH_IN-1]}}, din};
    rnd = ext + RND_C;
    shd = rnd >>> SHIFT;
  end

  if (!sat_needed(WIDTH_IN, SHIFT, WIDTH_OUT)) begin : g_extend
    always_comb begin
      dout = WIDTH_OUT'(shd);
      sat  = 1'b0;
    end
  end else begin : g_saturate
    localparam logic signed [W_WORK-1:0] SAT_MAX =
      {{(W_WORK-WIDTH_OUT+1){1'b0}}, {(WIDTH_OUT-1){1'b1}}};
    localparam logic signed [W_WORK-1:0] SAT_MIN =
      {{(W_WORK-WIDTH_OUT+1){1'b1}}, {(WIDTH_OUT-1){1'b0}}};
    localparam logic signed [WIDTH_OUT-1:0] OUT_MAX = {1'b0, {(WIDTH_OUT-1){1'b1}}};
    localparam logic signed [WIDTH_OUT-1:0] OUT_MIN = {1'b1, {(WIDTH_OUT-1){1'b0}}};

    always_comb begin
      dout = WIDTH_OUT'(shd);
      sat  = 1'b0;
      if (shd > SAT_MAX) begin
        dout = OUT_MAX;
        sat  = 1'b1;
      end else if (shd < SAT_MIN) begin
        dout = OUT_MIN;
        sat  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/complex_mult_pipe.sv
// Three-stage signed complex multiplier (a*b or a*conj(b)) with rounding, saturation
// and a valid/ready handshake; every stage stalls together under output backpressure.
module complex_mult_pipe
  import complex_mult_pipe_pkg::*;
#(
  parameter int DINA_WIDTH = 8,
  parameter int DINB_WIDTH = 8,
  parameter int OUT_SHIFT  = 0,
  parameter int DOUT_WIDTH = 17
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         din_valid,
  output logic                         din_ready,
  input  logic                         conj_en,
  input  logic signed [DINA_WIDTH-1:0] dina_i,
  input  logic signed [DINA_WIDTH-1:0] dina_q,
  input  logic signed [DINB_WIDTH-1:0] dinb_i,
  input  logic signed [DINB_WIDTH-1:0] dinb_q,
  output logic                         dout_valid,
  input  logic                         dout_ready,
  output logic signed [DOUT_WIDTH-1:0] mult_i,
  output logic signed [DOUT_WIDTH-1:0] mult_q,
  output logic                         dout_sat
);

  localparam int FULL_WIDTH = full_width(DINA_WIDTH, DINB_WIDTH);
  localparam int BQ_WIDTH   = DINB_WIDTH + 1;

  if (!params_legal(DINA_WIDTH, DINB_WIDTH, OUT_SHIFT, DOUT_WIDTH)) begin : g_bad_params
    $error("complex_mult_pipe: illegal parameters (DOUT_WIDTH<2 or OUT_SHIFT>=FULL_WIDTH)");
  end

  logic en;

  logic                         s1_valid_q, s1_valid_d;
  logic signed [DINA_WIDTH-1:0] s1_ai_q, s1_ai_d;
  logic signed [DINA_WIDTH-1:0] s1_aq_q, s1_aq_d;
  logic signed [DINB_WIDTH-1:0] s1_bi_q, s1_bi_d;
  logic signed [BQ_WIDTH-1:0]   s1_bq_q, s1_bq_d;
  logic signed [BQ_WIDTH-1:0]   bq_ext;

  logic                         s2_valid_q, s2_valid_d;
  logic signed [FULL_WIDTH-1:0] s2_p_ii_q, s2_p_ii_d;
  logic signed [FULL_WIDTH-1:0] s2_p_qq_q, s2_p_qq_d;
  logic signed [FULL_WIDTH-1:0] s2_p_iq_q, s2_p_iq_d;
  logic signed [FULL_WIDTH-1:0] s2_p_qi_q, s2_p_qi_d;

  logic signed [FULL_WIDTH-1:0] full_i;
  logic signed [FULL_WIDTH-1:0] full_q;
  logic signed [DOUT_WIDTH-1:0] rs_i;
  logic signed [DOUT_WIDTH-1:0] rs_q;
  logic                         sat_i;
  logic                         sat_q;

  logic                         dout_valid_q, dout_valid_d;
  logic signed [DOUT_WIDTH-1:0] mult_i_q, mult_i_d;
  logic signed [DOUT_WIDTH-1:0] mult_q_q, mult_q_d;
  logic                         dout_sat_q, dout_sat_d;

  // Ready depends only on registered state, never on din_valid.
  assign en        = ~dout_valid_q | dout_ready;
  assign din_ready = en;

  // Stage 1: conj folds into b_q here; the extra bit keeps -(-2^(N-1)) representable.
  always_comb begin
    bq_ext     = {dinb_q[DINB_WIDTH-1], dinb_q};
    s1_valid_d = s1_valid_q;
    s1_ai_d    = s1_ai_q;
    s1_aq_d    = s1_aq_q;
    s1_bi_d    = s1_bi_q;
    s1_bq_d    = s1_bq_q;
    if (en) begin
      s1_valid_d = din_valid;
      if (din_valid) begin
        s1_ai_d = dina_i;
        s1_aq_d = dina_q;
        s1_bi_d = dinb_i;
        s1_bq_d = conj_en ? -bq_ext : bq_ext;
      end
    end
  end

  always_comb begin
    s2_valid_d = s2_valid_q;
    s2_p_ii_d  = s2_p_ii_q;
    s2_p_qq_d  = s2_p_qq_q;
    s2_p_iq_d  = s2_p_iq_q;
    s2_p_qi_d  = s2_p_qi_q;
    if (en) begin
      s2_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        s2_p_ii_d = FULL_WIDTH'(s1_ai_q) * FULL_WIDTH'(s1_bi_q);
        s2_p_qq_d = FULL_WIDTH'(s1_aq_q) * FULL_WIDTH'(s1_bq_q);
        s2_p_iq_d = FULL_WIDTH'(s1_ai_q) * FULL_WIDTH'(s1_bq_q);
        s2_p_qi_d = FULL_WIDTH'(s1_aq_q) * FULL_WIDTH'(s1_bi_q);
      end
    end
  end

  always_comb begin
    full_i = s2_p_ii_q - s2_p_qq_q;
    full_q = s2_p_iq_q + s2_p_qi_q;
  end

  complex_mult_pipe_round_sat #(
    .WIDTH_IN (FULL_WIDTH),
    .SHIFT    (OUT_SHIFT),
    .WIDTH_OUT(DOUT_WIDTH)
  ) u_round_sat_i (
    .din (full_i),
    .dout(rs_i),
    .sat (sat_i)
  );

  complex_mult_pipe_round_sat #(
    .WIDTH_IN (FULL_WIDTH),
    .SHIFT    (OUT_SHIFT),
    .WIDTH_OUT(DOUT_WIDTH)
  ) u_round_sat_q (
    .din (full_q),
    .dout(rs_q),
    .sat (sat_q)
  );

  // Output register keeps the last result across bubbles so it only moves on real samples.
  always_comb begin
    dout_valid_d = dout_valid_q;
    mult_i_d     = mult_i_q;
    mult_q_d     = mult_q_q;
    dout_sat_d   = dout_sat_q;
    if (en) begin
      dout_valid_d = s2_valid_q;
      if (s2_valid_q) begin
        mult_i_d   = rs_i;
        mult_q_d   = rs_q;
        dout_sat_d = sat_i | sat_q;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_q   <= 1'b0;
      s1_ai_q      <= '0;
      s1_aq_q      <= '0;
      s1_bi_q      <= '0;
      s1_bq_q      <= '0;
      s2_valid_q   <= 1'b0;
      s2_p_ii_q    <= '0;
      s2_p_qq_q    <= '0;
      s2_p_iq_q    <= '0;
      s2_p_qi_q    <= '0;
      dout_valid_q <= 1'b0;
      mult_i_q     <= '0;
      mult_q_q     <= '0;
      dout_sat_q   <= 1'b0;
    end else begin
      s1_valid_q   <= s1_valid_d;
      s1_ai_q      <= s1_ai_d;
      s1_aq_q      <= s1_aq_d;
      s1_bi_q      <= s1_bi_d;
      s1_bq_q      <= s1_bq_d;
      s2_valid_q   <= s2_valid_d;
      s2_p_ii_q    <= s2_p_ii_d;
      s2_p_qq_q    <= s2_p_qq_d;
      s2_p_iq_q    <= s2_p_iq_d;
      s2_p_qi_q    <= s2_p_qi_d;
      dout_valid_q <= dout_valid_d;
      mult_i_q     <= mult_i_d;
      mult_q_q     <= mult_q_d;
      dout_sat_q   <= dout_sat_d;
    end
  end

  assign dout_valid = dout_valid_q;
  assign mult_i     = mult_i_q;
  assign mult_q     = mult_q_q;
  assign dout_sat   = dout_sat_q;

endmodule

// File: tb/tb_complex_mult_pipe.sv
// Scoreboard bench: default instance plus an OUT_SHIFT=4 / DOUT_WIDTH=8 instance on shared stimulus.
module tb_complex_mult_pipe;

  logic clk = 1'b0;
  logic rst;
  logic din_valid, conj_en, dout_ready;
  logic signed [7:0] dina_i, dina_q, dinb_i, dinb_q;
  logic din_ready, dout_valid, dout_sat;
  logic signed [16:0] mult_i, mult_q;
  logic din_ready_s, dout_valid_s, dout_sat_s;
  logic signed [7:0] mult_i_s, mult_q_s;

  int tests_run = 0;
  int tests_failed = 0;
  int rx_count = 0;

  typedef struct {
    longint i0, q0;
    bit     s0;
    longint i1, q1;
    bit     s1;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  complex_mult_pipe u_dut (
    .clk(clk), .rst(rst), .din_valid(din_valid), .din_ready(din_ready), .conj_en(conj_en),
    .dina_i(dina_i), .dina_q(dina_q), .dinb_i(dinb_i), .dinb_q(dinb_q),
    .dout_valid(dout_valid), .dout_ready(dout_ready), .mult_i(mult_i), .mult_q(mult_q),
    .dout_sat(dout_sat)
  );

  complex_mult_pipe #(.DINA_WIDTH(8), .DINB_WIDTH(8), .OUT_SHIFT(4), .DOUT_WIDTH(8)) u_dut_sh (
    .clk(clk), .rst(rst), .din_valid(din_valid), .din_ready(din_ready_s), .conj_en(conj_en),
    .dina_i(dina_i), .dina_q(dina_q), .dinb_i(dinb_i), .dinb_q(dinb_q),
    .dout_valid(dout_valid_s), .dout_ready(dout_ready), .mult_i(mult_i_s), .mult_q(mult_q_s),
    .dout_sat(dout_sat_s)
  );

  function automatic longint rs(input longint x, input int sh, input int w, output bit s);
    longint r, mx, mn;
    r = x;
    if (sh > 0) r = (x + (longint'(1) <<< (sh - 1))) >>> sh;
    mx = (longint'(1) <<< (w - 1)) - 1;
    mn = -(longint'(1) <<< (w - 1));
    s = 1'b0;
    if (r > mx) begin r = mx; s = 1'b1; end
    else if (r < mn) begin r = mn; s = 1'b1; end
    return r;
  endfunction

  function automatic exp_t model(input longint ai, input longint aq, input longint bi,
                                 input longint bq, input bit conj);
    exp_t e;
    longint bqp, fi, fq;
    bit si, sq;
    bqp = conj ? -bq : bq;
    fi = ai * bi - aq * bqp;
    fq = ai * bqp + aq * bi;
    e.i0 = rs(fi, 0, 17, si);
    e.q0 = rs(fq, 0, 17, sq);
    e.s0 = si | sq;
    e.i1 = rs(fi, 4, 8, si);
    e.q1 = rs(fq, 4, 8, sq);
    e.s1 = si | sq;
    return e;
  endfunction

  // Scoreboard: push on input handshake, pop/compare on output handshake.
  always @(negedge clk) begin
    exp_t e;
    if (rst === 1'b0) begin
      if (dout_valid && dout_ready) begin
        tests_run++;
        if (sb.size() == 0) begin
          tests_failed++;
          $display("FAIL sb_underflow: result %0d,%0d with nothing expected", mult_i, mult_q);
        end else begin
          e = sb.pop_front();
          rx_count++;
          if (longint'(mult_i) !== e.i0 || longint'(mult_q) !== e.q0 || dout_sat !== e.s0 ||
              dout_valid_s !== 1'b1 || longint'(mult_i_s) !== e.i1 ||
              longint'(mult_q_s) !== e.q1 || dout_sat_s !== e.s1) begin
            tests_failed++;
            $display("FAIL sb_result: got (%0d,%0d,%0b)/(%0d,%0d,%0b,v%0b) want (%0d,%0d,%0b)/(%0d,%0d,%0b)",
                     mult_i, mult_q, dout_sat, mult_i_s, mult_q_s, dout_sat_s, dout_valid_s,
                     e.i0, e.q0, e.s0, e.i1, e.q1, e.s1);
          end
        end
      end
      if (din_valid && din_ready)
        sb.push_back(model(dina_i, dina_q, dinb_i, dinb_q, conj_en));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int ai, input int aq, input int bi, input int bq, input bit conj);
    din_valid = 1'b1;
    dina_i = 8'(ai);
    dina_q = 8'(aq);
    dinb_i = 8'(bi);
    dinb_q = 8'(bq);
    conj_en = conj;
  endtask

  task automatic drain();
    for (int k = 0; k < 20 && (sb.size() != 0 || dout_valid); k++) tick();
    tests_run++;
    if (sb.size() != 0 || dout_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL drain_timeout: pending %0d, dout_valid %0b, want 0 and 0", sb.size(), dout_valid);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    din_valid = 1'b0;
    dout_ready = 1'b1;
    drive(0, 0, 0, 0, 1'b0);
    din_valid = 1'b0;
    tick();
    tick();
    tests_run++;
    if (dout_valid !== 1'b0 || mult_i !== 17'sd0 || mult_q !== 17'sd0 || dout_sat !== 1'b0 ||
        dout_valid_s !== 1'b0 || din_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL reset_state: valid=%0b i=%0d q=%0d sat=%0b valid_s=%0b ready=%0b want 0 0 0 0 0 1",
               dout_valid, mult_i, mult_q, dout_sat, dout_valid_s, din_ready);
    end
    @(negedge clk);
    rst = 1'b0;
    tick();
  endtask

  task automatic test_vector(input string name, input int ai, input int aq, input int bi,
                             input int bq, input bit conj,
                             input int ei, input int eq, input bit es,
                             input int ei2, input int eq2, input bit es2);
    logic [2:0] vhist;
    drain();
    dout_ready = 1'b1;
    drive(ai, aq, bi, bq, conj);
    tick();
    din_valid = 1'b0;
    vhist[0] = dout_valid;
    tick();
    vhist[1] = dout_valid;
    tick();
    vhist[2] = dout_valid;
    tests_run++;
    if (vhist !== 3'b100) begin
      tests_failed++;
      $display("FAIL %s_latency: valid after edges 1..3 = %b (edge3..1), want 100", name, vhist);
    end
    tests_run++;
    if (mult_i !== 17'(ei) || mult_q !== 17'(eq) || dout_sat !== es) begin
      tests_failed++;
      $display("FAIL %s_default: got (%0d,%0d,%0b) want (%0d,%0d,%0b)", name, mult_i, mult_q, dout_sat,
               ei, eq, es);
    end
    tests_run++;
    if (mult_i_s !== 8'(ei2) || mult_q_s !== 8'(eq2) || dout_sat_s !== es2) begin
      tests_failed++;
      $display("FAIL %s_shift4: got (%0d,%0d,%0b) want (%0d,%0d,%0b)", name, mult_i_s, mult_q_s,
               dout_sat_s, ei2, eq2, es2);
    end
  endtask

  task automatic test_back_to_back();
    logic [19:0] hist;
    logic [19:0] exp_hist;
    drain();
    dout_ready = 1'b1;
    exp_hist = 20'h003FC;
    for (int c = 0; c < 20; c++) begin
      if (c < 8) drive(int'($urandom), int'($urandom), int'($urandom), int'($urandom), c[0]);
      else din_valid = 1'b0;
      tick();
      hist[c] = dout_valid;
    end
    tests_run++;
    if (hist !== exp_hist) begin
      tests_failed++;
      $display("FAIL b2b_valid_run: valid history %b want %b", hist, exp_hist);
    end
  endtask

  task automatic test_backpressure();
    int sent, rx0, stall_cycles;
    bit was_stalled;
    logic [50:0] held;
    drain();
    sent = 0;
    rx0 = rx_count;
    stall_cycles = 0;
    was_stalled = 1'b0;
    held = '0;
    for (int c = 0; c < 60; c++) begin
      dout_ready = !(c >= 6 && c < 11);
      if (sent < 10) drive(int'($urandom), int'($urandom), int'($urandom), int'($urandom), c[1]);
      else din_valid = 1'b0;
      @(negedge clk);
      if (!dout_ready && dout_valid) begin
        stall_cycles++;
        tests_run++;
        if (din_ready !== 1'b0 || din_ready_s !== 1'b0) begin
          tests_failed++;
          $display("FAIL bp_din_ready: got %0b/%0b want 0 during stall", din_ready, din_ready_s);
        end
        if (was_stalled) begin
          tests_run++;
          if ({mult_i, mult_q, dout_sat, mult_i_s, mult_q_s} !== held) begin
            tests_failed++;
            $display("FAIL bp_hold: outputs %h want held %h",
                     {mult_i, mult_q, dout_sat, mult_i_s, mult_q_s}, held);
          end
        end
        held = {mult_i, mult_q, dout_sat, mult_i_s, mult_q_s};
        was_stalled = 1'b1;
      end else begin
        was_stalled = 1'b0;
      end
      if (din_valid && din_ready) sent++;
      tick();
      if (sent == 10 && sb.size() == 0 && !dout_valid) break;
    end
    dout_ready = 1'b1;
    tests_run++;
    if (sent != 10 || rx_count - rx0 != 10 || sb.size() != 0 || stall_cycles != 5) begin
      tests_failed++;
      $display("FAIL bp_count: sent %0d rx %0d pending %0d stalls %0d want 10 10 0 5",
               sent, rx_count - rx0, sb.size(), stall_cycles);
    end
  endtask

  task automatic test_reset_midflight();
    logic any_valid;
    drain();
    dout_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      drive(3 + k, 4, 5, -2, k[0]);
      tick();
    end
    din_valid = 1'b0;
    tests_run++;
    if (dout_valid !== 1'b1) begin
      tests_failed++;
      $display("FAIL rstmid_pre: dout_valid %0b want 1 before reset", dout_valid);
    end
    #2;
    rst = 1'b1;
    #1;
    tests_run++;
    if (dout_valid !== 1'b0 || mult_i !== 17'sd0 || mult_q !== 17'sd0 || dout_sat !== 1'b0 ||
        dout_valid_s !== 1'b0 || mult_i_s !== 8'sd0 || mult_q_s !== 8'sd0) begin
      tests_failed++;
      $display("FAIL rstmid_async: valid=%0b i=%0d q=%0d sat=%0b valid_s=%0b want all 0",
               dout_valid, mult_i, mult_q, dout_sat, dout_valid_s);
    end
    sb.delete();
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    tick();
    any_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      any_valid = any_valid | dout_valid | dout_valid_s;
      tick();
    end
    tests_run++;
    if (any_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL rstmid_flush: dout_valid seen %0b after reset, want 0", any_valid);
    end
    test_vector("post_reset", 3, 4, 5, -2, 1'b0, 23, 14, 1'b0, 1, 1, 1'b0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_vector("basic", 3, 4, 5, -2, 1'b0, 23, 14, 1'b0, 1, 1, 1'b0);
    test_vector("conj", 3, 4, 5, -2, 1'b1, 7, 26, 1'b0, 0, 2, 1'b0);
    test_vector("corner", -128, -128, -128, 127, 1'b0, 32640, 128, 1'b0, 127, 8, 1'b1);
    test_vector("corner_conj", -128, -128, -128, -128, 1'b1, 32768, 0, 1'b0, 127, 0, 1'b1);
    test_back_to_back();
    test_backpressure();
    test_reset_midflight();
    drain();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
